// File: rtl/usb_rx_pkg.sv
// Shared types and default constants for the USB full-speed receive framer.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    EOP_WAIT,
    ERROR
  } rx_state_t;

  // Sync pattern KJKJKJKK decodes to 0000_0001 on the wire, i.e. 8'h80 LSB-first.
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'h80;

  // Number of consecutive decoded 1s after which the transmitter inserts a 0.
  localparam int unsigned STUFF_LEN_DEF = 6;

endpackage

// File: rtl/usb_rx_framer_nrzi_decode.sv
// NRZI decoder: a level repeated from the previous bit centre is a 1, a change is a 0.
// The reference level is parked at J (1) whenever the framer is idle.
module nrzi_decode (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_i,
  input  logic shift_en_i,
  input  logic eop_i,
  input  logic clear_i,
  output logic bit_o,
  output logic valid_o
);

  logic prev_bit_q;
  logic prev_bit_d;

  // Track the line level at the last bit centre; SE0 periods never update it.
  always_comb begin
    prev_bit_d = prev_bit_q;
    if (clear_i) begin
      prev_bit_d = 1'b1;
    end else if (shift_en_i && !eop_i) begin
      prev_bit_d = d_plus_i;
    end
  end

  // Reference level register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_bit_q <= 1'b1;
    end else begin
      prev_bit_q <= prev_bit_d;
    end
  end

  assign bit_o   = (d_plus_i == prev_bit_q);
  assign valid_o = shift_en_i & ~eop_i & ~clear_i;

endmodule

// File: rtl/usb_rx_framer.sv
// USB full-speed receive framer: sync check, byte assembly and FIFO write strobe.
// Optional bit-unstuffing is compiled in when BIT_STUFF_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | bus at J, waiting for the first K of a sync pattern
//   SYNC     | assembling the first byte, must equal SYNC_BYTE
//   RECEIVE  | assembling data bytes, each one written to the FIFO
//   EOP_WAIT | clean end of packet, waiting for SE0 to return to J
//   ERROR    | framing fault, waiting for SE0 followed by J
module usb_rx_framer
  import usb_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
`ifdef BIT_STUFF_EN
  ,
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       eop,
  input  logic       shift_enable,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_data,
  output logic       r_error
);

  rx_state_t  state_q, state_d;

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       w_en_q, w_en_d;
  logic       r_err_q, r_err_d;
  logic       eop_seen_q, eop_seen_d;

  logic       nrzi_clear;
  logic       dec_bit;
  logic       dec_valid;
  logic       in_frame;
  logic       stuff_slot;
  logic       bit_take;
  logic       stuff_err;
  logic       byte_done;
  logic [7:0] byte_nxt;

`ifdef BIT_STUFF_EN
  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  logic [OW-1:0] ones_q, ones_d;
  assign stuff_slot = (ones_q == OW'(STUFF_LEN));
`else
  assign stuff_slot = 1'b0;
`endif

  nrzi_decode u_nrzi (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus_i   (d_plus_sync),
    .shift_en_i (shift_enable),
    .eop_i      (eop),
    .clear_i    (nrzi_clear),
    .bit_o      (dec_bit),
    .valid_o    (dec_valid)
  );

  // A stuffed bit is consumed by the decoder but never reaches the shift register.
  assign in_frame  = (state_q == SYNC) || (state_q == RECEIVE);
  assign bit_take  = dec_valid && in_frame && !stuff_slot;
  assign stuff_err = dec_valid && in_frame && stuff_slot && dec_bit;
  assign byte_nxt  = {dec_bit, sr_q[7:1]};
  assign byte_done = bit_take && (cnt_q == 3'd7);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!d_plus_sync && !eop) state_d = SYNC;
      end
      SYNC: begin
        if (eop || stuff_err) begin
          state_d = ERROR;
        end else if (byte_done) begin
          state_d = (byte_nxt == SYNC_BYTE) ? RECEIVE : ERROR;
        end
      end
      RECEIVE: begin
        // An SE0 that starts mid-byte is a framing error straight away; on a
        // byte boundary the packet ends at the next bit centre.
        if (eop) begin
          if (cnt_q != 3'd0) begin
            state_d = ERROR;
          end else if (shift_enable) begin
            state_d = EOP_WAIT;
          end
        end else if (stuff_err) begin
          state_d = ERROR;
        end
      end
      EOP_WAIT: begin
        if (!eop && d_plus_sync) state_d = IDLE;
      end
      ERROR: begin
        if (eop_seen_q && !eop && d_plus_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    rcving     = (state_q != IDLE);
    nrzi_clear = (state_q == IDLE);
    w_enable   = w_en_q;
    rx_data    = rx_data_q;
    r_error    = r_err_q;
  end

  // Datapath next values: shift register, bit counter, write strobe and error flag.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    w_en_d     = 1'b0;
    r_err_d    = r_err_q;
    eop_seen_d = eop_seen_q;

    if (state_q == IDLE) begin
      cnt_d      = 3'd0;
      eop_seen_d = 1'b0;
    end else if (bit_take) begin
      sr_d  = byte_nxt;
      cnt_d = cnt_q + 3'd1;
    end

    if ((state_q == RECEIVE) && byte_done) begin
      w_en_d    = 1'b1;
      rx_data_d = byte_nxt;
    end

    // The error flag survives the return to IDLE and clears only on a new start.
    if ((state_q == IDLE) && (state_d == SYNC)) r_err_d = 1'b0;
    if (state_d == ERROR) r_err_d = 1'b1;

    // Leaving ERROR needs an SE0 first, so a J seen before the EOP cannot end it.
    if ((state_q != ERROR) && (state_d == ERROR)) begin
      eop_seen_d = eop;
    end else if ((state_q == ERROR) && eop) begin
      eop_seen_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q       <= 8'h00;
      cnt_q      <= 3'd0;
      rx_data_q  <= 8'h00;
      w_en_q     <= 1'b0;
      r_err_q    <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      w_en_q     <= w_en_d;
      r_err_q    <= r_err_d;
      eop_seen_q <= eop_seen_d;
    end
  end

`ifdef BIT_STUFF_EN
  // Run length of decoded 1s; the stuffed bit that follows a full run restarts it.
  always_comb begin
    ones_d = ones_q;
    if (state_q == IDLE) begin
      ones_d = '0;
    end else if (dec_valid && in_frame) begin
      if (stuff_slot || !dec_bit) begin
        ones_d = '0;
      end else begin
        ones_d = ones_q + OW'(1);
      end
    end
  end

  // Run-length register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end
`endif

endmodule
